// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file write-port arbiter:
//   - state_t      : arbiter state (clear sequence / live arbitration)
//   - RF_*         : default geometry of the KGP-RISC register file
//   - REQ_ALU/MEM  : requester index into the two-bit grant vector
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter2
// Two-requester round-robin grant. The grant is combinational from the
// request vector and a one-bit pointer that names the requester favoured on
// a tie. Every grant moves the favour to the other requester.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en       : arbitration enabled (no grants while low)
//   req[1:0] : request vector, indexed by REQ_ALU / REQ_MEM
//   gnt[1:0] : one-hot (or zero) grant vector, same indexing
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester that wins the next tie; reset lets the ALU win.
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[REQ_ALU] && req[REQ_MEM]) begin
                gnt[prio] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'(REQ_ALU);
        end else if (|gnt) begin
            prio <= gnt[REQ_ALU] ? 1'(REQ_MEM) : 1'(REQ_ALU);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the register file's single write port. After reset it writes zero to
// every register in turn, then shares the port round-robin between the ALU
// and load writeback requesters. The write command is registered; the write
// currently on the port is exposed for read-after-write forwarding.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   aluValid/aluAddr/aluData      : ALU writeback request
//   aluReady                      : ALU request accepted this cycle
//   memValid/memAddr/memData      : load writeback request
//   memReady                      : load request accepted this cycle
//   rfWe/rfAddr/rfData            : registered register-file write command
//   initDone                      : clear finished, arbitration live
//   qAddr1/qAddr2                 : read addresses presented to the regfile
//   fwd1Hit/fwd2Hit/fwdData       : in-flight write matches read address N
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int DATA_W   = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluAddr,
    input  logic [DATA_W-1:0] aluData,
    output logic              aluReady,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    output logic              memReady,
    output logic              rfWe,
    output logic [ADDR_W-1:0] rfAddr,
    output logic [DATA_W-1:0] rfData,
    output logic              initDone,
    input  logic [ADDR_W-1:0] qAddr1,
    input  logic [ADDR_W-1:0] qAddr2,
    output logic              fwd1Hit,
    output logic              fwd2Hit,
    output logic [DATA_W-1:0] fwdData
);

    localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             clr_last;
    logic [1:0]       gnt;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_RUN),
        .req ({memValid, aluValid}),
        .gnt (gnt)
    );

    assign aluReady = gnt[REQ_ALU];
    assign memReady = gnt[REQ_MEM];

    // Last clear write is being issued on this edge.
    assign clr_last = (state == ST_INIT) && (cnt == CNT_W'(NUM_REGS - 1));

    always_comb begin
        state_nxt = state;
        if (clr_last) begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- write-command stage: inputs -> registered regfile port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rfWe     <= 1'b0;
            rfAddr   <= '0;
            rfData   <= '0;
            initDone <= 1'b0;
        end else if (state == ST_INIT) begin
            rfWe   <= 1'b1;
            rfAddr <= ADDR_W'(cnt);
            rfData <= '0;
            cnt    <= cnt + CNT_W'(1);
            if (clr_last) begin
                initDone <= 1'b1;
            end
        end else if (gnt[REQ_ALU]) begin
            rfWe   <= 1'b1;
            rfAddr <= aluAddr;
            rfData <= aluData;
        end else if (gnt[REQ_MEM]) begin
            rfWe   <= 1'b1;
            rfAddr <= memAddr;
            rfData <= memData;
        end else begin
            // Address/data hold so the forwarding outputs stay quiet.
            rfWe <= 1'b0;
        end
    end

    // ---- forwarding of the write currently on the port ----
    assign fwd1Hit = rfWe && (rfAddr == qAddr1);
    assign fwd2Hit = rfWe && (rfAddr == qAddr2);
    assign fwdData = rfData;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal
// expectations, then randomized requesters checked each cycle against a
// behavioural model of the write port.
module tb_regfile_write_arbiter;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aluValid = 1'b0, memValid = 1'b0;
    logic [4:0]  aluAddr = '0, memAddr = '0, qAddr1 = '0, qAddr2 = '0;
    logic [31:0] aluData = '0, memData = '0;
    logic        aluReady, memReady, rfWe, initDone, fwd1Hit, fwd2Hit;
    logic [4:0]  rfAddr;
    logic [31:0] rfData, fwdData;

    int n_tests = 0;
    int n_fail  = 0;
    logic cmp_on = 1'b0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memAddr(memAddr), .memData(memData), .memReady(memReady),
        .rfWe(rfWe), .rfAddr(rfAddr), .rfData(rfData), .initDone(initDone),
        .qAddr1(qAddr1), .qAddr2(qAddr2),
        .fwd1Hit(fwd1Hit), .fwd2Hit(fwd2Hit), .fwdData(fwdData)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_edges: edges since reset release (saturating at NR); clear phase is
    // the first NR of them. m_last_mem: most recent grant went to MEM.
    int          m_edges = 0;
    logic        m_last_mem = 1'b1;
    logic        m_we = 1'b0, m_done = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    // bit0 = ALU ready, bit1 = MEM ready
    function automatic logic [1:0] exp_ready(input logic av, input logic mv);
        logic [1:0] r;
        r = 2'b00;
        if (m_edges >= NR) begin
            if (av && mv) r = m_last_mem ? 2'b01 : 2'b10;
            else          r = {mv, av};
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] r;
        if (rst) begin
            m_edges = 0; m_last_mem = 1'b1; m_we = 1'b0;
            m_addr = '0; m_data = '0; m_done = 1'b0;
        end else begin
            r = exp_ready(aluValid, memValid);
            if (m_edges < NR) begin
                m_we = 1'b1; m_addr = 5'(m_edges); m_data = '0;
                if (m_edges == NR - 1) m_done = 1'b1;
            end else if (r[0]) begin
                m_we = 1'b1; m_addr = aluAddr; m_data = aluData; m_last_mem = 1'b0;
            end else if (r[1]) begin
                m_we = 1'b1; m_addr = memAddr; m_data = memData; m_last_mem = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (m_edges < NR) m_edges++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [1:0] r;
        if (cmp_on) begin
            r = exp_ready(aluValid, memValid);
            chk("m_rfWe",     rfWe,     m_we);
            chk("m_rfAddr",   rfAddr,   m_addr);
            chk("m_rfData",   rfData,   m_data);
            chk("m_initDone", initDone, m_done);
            chk("m_aluReady", aluReady, r[0]);
            chk("m_memReady", memReady, r[1]);
            chk("m_fwd1Hit",  fwd1Hit,  m_we && (m_addr == qAddr1));
            chk("m_fwd2Hit",  fwd2Hit,  m_we && (m_addr == qAddr2));
            chk("m_fwdData",  fwdData,  m_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic alu_acc, mem_acc;
        alu_acc = 1'b0; mem_acc = 1'b0;

        // Reset held, then clear with no requests.
        repeat (3) tick();
        cmp_on = 1'b1;
        chk("rst_rfWe", rfWe, 0);
        chk("rst_rfAddr", rfAddr, 0);
        chk("rst_initDone", initDone, 0);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) begin
            tick();
            chk("clr_we", rfWe, 1);
            chk("clr_addr", rfAddr, k);
            chk("clr_data", rfData, 0);
            chk("clr_done", initDone, (k == NR - 1) ? 1 : 0);
        end
        tick();
        chk("idle_we", rfWe, 0);

        // ALU only: reg1 <= 16.
        aluValid = 1'b1; aluAddr = 5'd1; aluData = 32'd16;
        #1;
        chk("alu1_ready", aluReady, 1);
        chk("alu1_memready", memReady, 0);
        tick();
        aluValid = 1'b0;
        chk("alu1_we", rfWe, 1);
        chk("alu1_addr", rfAddr, 1);
        chk("alu1_data", rfData, 16);

        // MEM only: reg4 <= 7 (makes MEM the most recent grant).
        memValid = 1'b1; memAddr = 5'd4; memData = 32'd7;
        tick();
        memValid = 1'b0;
        chk("mem4_addr", rfAddr, 4);
        chk("mem4_data", rfData, 7);

        // Both valid for 4 cycles: ALU, MEM, ALU, MEM.
        aluValid = 1'b1; aluAddr = 5'd2; aluData = 32'd22;
        memValid = 1'b1; memAddr = 5'd3; memData = 32'd10;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_aluReady", aluReady, (k % 2 == 0) ? 1 : 0);
            chk("tie_memReady", memReady, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("tie_addr", rfAddr, (k % 2 == 0) ? 2 : 3);
            chk("tie_data", rfData, (k % 2 == 0) ? 22 : 10);
        end
        aluValid = 1'b0; memValid = 1'b0;

        // Forwarding: write reg5 <= 9 in flight.
        aluValid = 1'b1; aluAddr = 5'd5; aluData = 32'd9;
        tick();
        aluValid = 1'b0; qAddr1 = 5'd5; qAddr2 = 5'd6;
        #1;
        chk("fwd1Hit", fwd1Hit, 1);
        chk("fwd2Hit", fwd2Hit, 0);
        chk("fwdData", fwdData, 9);

        // Reset mid-run, then mid-clear at address 10.
        rst = 1'b1;
        #1;
        chk("rstrun_we", rfWe, 0);
        chk("rstrun_done", initDone, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k <= 10; k++) tick();
        chk("clr10_addr", rfAddr, 10);
        rst = 1'b1;
        #1;
        chk("rst10_we", rfWe, 0);
        chk("rst10_addr", rfAddr, 0);
        tick();
        rst = 1'b0;
        // Load request pending throughout the restarted clear.
        memValid = 1'b1; memAddr = 5'd7; memData = 32'd77;
        for (int k = 0; k < NR - 1; k++) begin
            tick();
            chk("reclr_addr", rfAddr, k);
            chk("reclr_done", initDone, 0);
            #1;
            chk("reclr_memReady", memReady, 0);
        end
        tick();
        chk("reclr_last", rfAddr, NR - 1);
        chk("reclr_done_last", initDone, 1);
        #1;
        chk("first_run_memReady", memReady, 1);
        tick();
        memValid = 1'b0;
        chk("first_run_we", rfWe, 1);
        chk("first_run_addr", rfAddr, 7);
        chk("first_run_data", rfData, 77);

        // Randomized requesters obeying hold-until-accepted.
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (alu_acc || !aluValid) begin
                aluValid = ($urandom_range(0, 3) != 0);
                aluAddr  = 5'($urandom_range(0, 7));
                aluData  = $urandom;
            end
            if (mem_acc || !memValid) begin
                memValid = ($urandom_range(0, 2) != 0);
                memAddr  = 5'($urandom_range(0, 7));
                memData  = $urandom;
            end
            qAddr1 = 5'($urandom_range(0, 7));
            qAddr2 = 5'($urandom_range(0, 7));
            #1;
            alu_acc = aluValid && aluReady;
            mem_acc = memValid && memReady;
        end

        tick();
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
